// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the accumulator CPU control path.
//   - short (mode 0) and long (mode 1) opcode encodings
//   - ALU function codes driven by the sequencer
//   - sequencer state enumeration and decoded-instruction enumeration
//   - decode_op(): maps IR[15:12] to a decoded instruction class
package cpu_pkg;

  localparam int ADDR_W = 12;

  // Short opcodes, op[3] = 0, encoded in op[2:0]
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_CLA = 3'b011;
  localparam logic [2:0] OP_COM = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;

  // Long opcodes, op[3] = 1, full 4-bit code
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_BAN = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_CSL = 4'b1110;
  localparam logic [3:0] OP_STP = 4'b1111;

  // ALU function codes
  localparam logic [3:0] ALU_CLA = 4'b0000;
  localparam logic [3:0] ALU_COM = 4'b0001;
  localparam logic [3:0] ALU_SHR = 4'b0010;
  localparam logic [3:0] ALU_CSL = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_STA = 4'b0101;
  localparam logic [3:0] ALU_LDA = 4'b0110;
  localparam logic [3:0] ALU_BAN = 4'b0111;
  localparam logic [3:0] ALU_JMP = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPRD, S_OPWR, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_STA, I_LDA, I_CLA, I_COM, I_JMP,
    I_ADD, I_BAN, I_SHR, I_CSL, I_STP
  } instr_t;

  function automatic instr_t decode_op(input logic [3:0] op);
    instr_t r;
    r = I_ILL;
    if (!op[3]) begin
      case (op[2:0])
        OP_STA:  r = I_STA;
        OP_LDA:  r = I_LDA;
        OP_CLA:  r = I_CLA;
        OP_COM:  r = I_COM;
        OP_JMP:  r = I_JMP;
        default: r = I_ILL;
      endcase
    end else begin
      case (op)
        OP_ADD:  r = I_ADD;
        OP_BAN:  r = I_BAN;
        OP_SHR:  r = I_SHR;
        OP_CSL:  r = I_CSL;
        OP_STP:  r = I_STP;
        default: r = I_ILL;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the accumulator CPU.
// Steps each instruction through FETCH/DECODE/OPRD|OPWR/EXEC, drives the
// datapath write strobes and ALU code, and runs a req/ack memory handshake
// with a timeout watchdog.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           restart pulse, only honoured in HALT
//   op              IR[15:12]; acc_neg = ACC sign bit; mem_ack = memory done
//   mem_req/mem_we/addr_sel             memory request controls
//   ir_we/mdr_we/pc_we/pc_sel/acc_we    datapath strobes; alu_op = ALU code
//   halted, illegal, bus_err            status (flags sticky until restart)
//   instr_cnt       retired-instruction counter (wraps)
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter bit AUTO_START = 1'b1,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             acc_neg,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             acc_we,
  output logic [3:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  // Wait counter only has to reach TIMEOUT-1: the timeout fires in the
  // cycle that would have taken it to TIMEOUT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;
  logic              mem_state;
  logic              timeout_hit;
  instr_t            instr;

  always_comb instr = decode_op(op);

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_OPRD) || (state_q == S_OPWR);
  // An ack in the timeout cycle wins, hence the !mem_ack term.
  assign timeout_hit = (TIMEOUT != 0) && mem_state && !mem_ack && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    // Counter is zero outside a stalled memory cycle, so every memory
    // state is entered with a cleared count.
    wait_d    = '0;
    if (mem_state && !mem_ack) wait_d = wait_q + WAIT_W'(1);

    case (state_q)
      S_FETCH: begin
        if (mem_ack) state_d = S_DECODE;
        else if (timeout_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (instr)
          I_LDA, I_ADD: state_d = S_OPRD;
          I_STA:        state_d = S_OPWR;
          I_STP: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          I_ILL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default:      state_d = S_EXEC;
        endcase
      end
      S_OPRD: begin
        if (mem_ack) state_d = S_EXEC;
        else if (timeout_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_OPWR: begin
        if (mem_ack) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          illegal_d = 1'b0;
          bus_err_d = 1'b0;
        end
      end
      default: state_d = S_HALT;
    endcase

    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= AUTO_START ? S_FETCH : S_HALT;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Strobes decode the registered state; ir_we/mdr_we follow mem_ack.
  // Reset masks every strobe so an in-flight access cannot complete.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    acc_we   = 1'b0;
    alu_op   = ALU_CLA;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        S_DECODE: pc_we = 1'b1;
        S_OPRD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mdr_we   = mem_ack;
        end
        S_OPWR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          alu_op   = ALU_STA;
        end
        S_EXEC: begin
          case (instr)
            I_CLA: begin acc_we = 1'b1; alu_op = ALU_CLA; end
            I_COM: begin acc_we = 1'b1; alu_op = ALU_COM; end
            I_SHR: begin acc_we = 1'b1; alu_op = ALU_SHR; end
            I_CSL: begin acc_we = 1'b1; alu_op = ALU_CSL; end
            I_ADD: begin acc_we = 1'b1; alu_op = ALU_ADD; end
            I_LDA: begin acc_we = 1'b1; alu_op = ALU_LDA; end
            I_JMP: begin pc_we = 1'b1; pc_sel = 1'b1; alu_op = ALU_JMP; end
            I_BAN: begin pc_we = acc_neg; pc_sel = 1'b1; alu_op = ALU_BAN; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer. Each stimulus step
// describes one clock cycle and queues the outputs expected in that cycle;
// a negedge checker pops and compares. A second instance with
// AUTO_START = 0 checks reset-to-HALT and restart.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic       pc_sel;
    logic       acc_we;
    logic [3:0] alu_op;
    logic       halted;
    logic       illegal;
    logic       bus_err;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst, start, start_h, acc_neg, mem_ack;
  logic [3:0] op;

  logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, acc_we;
  logic [3:0] alu_op, instr_cnt;
  logic       halted, illegal, bus_err;

  logic       mem_req_h, mem_we_h, addr_sel_h, ir_we_h, mdr_we_h, pc_we_h, pc_sel_h, acc_we_h;
  logic [3:0] alu_op_h, instr_cnt_h;
  logic       halted_h, illegal_h, bus_err_h;

  obs_t obs, obs_h;
  assign obs   = {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, acc_we,
                  alu_op, halted, illegal, bus_err, instr_cnt};
  assign obs_h = {mem_req_h, mem_we_h, addr_sel_h, ir_we_h, mdr_we_h, pc_we_h, pc_sel_h,
                  acc_we_h, alu_op_h, halted_h, illegal_h, bus_err_h, instr_cnt_h};

  cpu_sequencer #(.AUTO_START(1'b1), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc_neg(acc_neg), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .acc_we(acc_we), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .instr_cnt(instr_cnt)
  );

  cpu_sequencer #(.AUTO_START(1'b0), .TIMEOUT(8), .CNT_W(4)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .op(op), .acc_neg(acc_neg), .mem_ack(mem_ack),
    .mem_req(mem_req_h), .mem_we(mem_we_h), .addr_sel(addr_sel_h), .ir_we(ir_we_h),
    .mdr_we(mdr_we_h), .pc_we(pc_we_h), .pc_sel(pc_sel_h), .acc_we(acc_we_h),
    .alu_op(alu_op_h), .halted(halted_h), .illegal(illegal_h), .bus_err(bus_err_h),
    .instr_cnt(instr_cnt_h)
  );

  always #5 clk = ~clk;

  int   total  = 0;
  int   passed = 0;
  sb_t  sb[$];
  sb_t  cur;

  logic       e_ill, e_berr;
  logic [3:0] e_cnt;

  // Expected-output builders, one per visible state
  function automatic obs_t base();
    obs_t o;
    o         = '0;
    o.illegal = e_ill;
    o.bus_err = e_berr;
    o.cnt     = e_cnt;
    return o;
  endfunction
  function automatic obs_t e_fetch(input logic ack);
    obs_t o = base();
    o.mem_req = 1'b1; o.ir_we = ack;
    return o;
  endfunction
  function automatic obs_t e_decode();
    obs_t o = base();
    o.pc_we = 1'b1;
    return o;
  endfunction
  function automatic obs_t e_oprd(input logic ack);
    obs_t o = base();
    o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mdr_we = ack;
    return o;
  endfunction
  function automatic obs_t e_opwr();
    obs_t o = base();
    o.mem_req = 1'b1; o.mem_we = 1'b1; o.addr_sel = 1'b1; o.alu_op = 4'b0101;
    return o;
  endfunction
  function automatic obs_t e_acc(input logic [3:0] code);
    obs_t o = base();
    o.acc_we = 1'b1; o.alu_op = code;
    return o;
  endfunction
  function automatic obs_t e_jmp();
    obs_t o = base();
    o.pc_we = 1'b1; o.pc_sel = 1'b1; o.alu_op = 4'b1111;
    return o;
  endfunction
  function automatic obs_t e_ban(input logic neg);
    obs_t o = base();
    o.pc_we = neg; o.pc_sel = 1'b1; o.alu_op = 4'b0111;
    return o;
  endfunction
  function automatic obs_t e_halt();
    obs_t o = base();
    o.halted = 1'b1;
    return o;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur   = sb.pop_front();
      total = total + 1;
      assert (obs === cur.v) begin
        passed = passed + 1;
      end else begin
        $error("FAIL %s: observed %h expected %h", cur.tag, obs, cur.v);
      end
    end
  end

  // One clock cycle: drive inputs, queue expected outputs, advance.
  task automatic cyc(input string tag, input obs_t e, input logic [3:0] o = 4'h0,
                     input logic a = 1'b0, input logic n = 1'b0,
                     input logic s = 1'b0, input logic r = 1'b0);
    sb_t item;
    op = o; mem_ack = a; acc_neg = n; start = s; rst = r;
    item.tag = tag;
    item.v   = e;
    sb.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_h(input string tag, input obs_t e);
    total = total + 1;
    assert (obs_h === e) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs_h, e);
    end
  endtask

  task automatic exec_acc(input string tag, input logic [3:0] o, input logic [3:0] code);
    cyc({tag, "_fetch"}, e_fetch(1'b1), o, 1'b1);
    cyc({tag, "_dec"},   e_decode(),    o, 1'b1);          // ack with no request
    cyc({tag, "_exec"},  e_acc(code),   o, 1'b0, 1'b0, 1'b1); // start outside HALT
    e_cnt = e_cnt + 4'd1;
  endtask

  obs_t hx;

  initial begin
    rst = 1'b1; start = 1'b0; start_h = 1'b0; acc_neg = 1'b0; mem_ack = 1'b0; op = 4'h0;
    e_ill = 1'b0; e_berr = 1'b0; e_cnt = 4'd0;
    @(posedge clk);
    #1;

    // Reset held: state FETCH but every strobe masked
    cyc("rst_hold", base(), 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    hx = '0; hx.halted = 1'b1;
    chk_h("h_reset_halt", hx);

    // cla, zero-wait
    exec_acc("cla", 4'b0011, 4'b0000);

    // lda with three wait cycles in OPRD
    cyc("lda_fetch", e_fetch(1'b1), 4'b0010, 1'b1);
    cyc("lda_dec",   e_decode(),    4'b0010);
    for (int i = 0; i < 3; i++) cyc("lda_wait", e_oprd(1'b0), 4'b0010);
    cyc("lda_ack",   e_oprd(1'b1),  4'b0010, 1'b1);
    cyc("lda_exec",  e_acc(4'b0110), 4'b0010);
    e_cnt = e_cnt + 4'd1;

    // add
    cyc("add_fetch", e_fetch(1'b1), 4'b1000, 1'b1);
    cyc("add_dec",   e_decode(),    4'b1000);
    cyc("add_rd",    e_oprd(1'b1),  4'b1000, 1'b1);
    cyc("add_exec",  e_acc(4'b0100), 4'b1000);
    e_cnt = e_cnt + 4'd1;

    // sta with one wait cycle
    cyc("sta_fetch", e_fetch(1'b1), 4'b0001, 1'b1);
    cyc("sta_dec",   e_decode(),    4'b0001);
    cyc("sta_wait",  e_opwr(),      4'b0001);
    cyc("sta_ack",   e_opwr(),      4'b0001, 1'b1);
    e_cnt = e_cnt + 4'd1;

    exec_acc("com", 4'b0100, 4'b0001);
    exec_acc("shr", 4'b1101, 4'b0010);
    exec_acc("csl", 4'b1110, 4'b0011);

    // jmp
    cyc("jmp_fetch", e_fetch(1'b1), 4'b0101, 1'b1);
    cyc("jmp_dec",   e_decode(),    4'b0101);
    cyc("jmp_exec",  e_jmp(),       4'b0101);
    e_cnt = e_cnt + 4'd1;

    // ban not taken, then taken
    cyc("ban0_fetch", e_fetch(1'b1), 4'b1100, 1'b1);
    cyc("ban0_dec",   e_decode(),    4'b1100);
    cyc("ban0_exec",  e_ban(1'b0),   4'b1100, 1'b0, 1'b0);
    e_cnt = e_cnt + 4'd1;
    cyc("ban1_fetch", e_fetch(1'b1), 4'b1100, 1'b1, 1'b1);
    cyc("ban1_dec",   e_decode(),    4'b1100, 1'b0, 1'b1);
    cyc("ban1_exec",  e_ban(1'b1),   4'b1100, 1'b0, 1'b1);
    e_cnt = e_cnt + 4'd1;

    // illegal opcode: halt, flag, not retired; restart clears flag
    cyc("ill_fetch", e_fetch(1'b1), 4'b1010, 1'b1);
    cyc("ill_dec",   e_decode(),    4'b1010);
    e_ill = 1'b1;
    cyc("ill_halt",  e_halt(),      4'b1010, 1'b1);
    cyc("ill_start", e_halt(),      4'b1010, 1'b0, 1'b0, 1'b1);
    e_ill = 1'b0;
    exec_acc("cla2", 4'b0011, 4'b0000);

    // stp retires and halts
    cyc("stp_fetch", e_fetch(1'b1), 4'b1111, 1'b1);
    cyc("stp_dec",   e_decode(),    4'b1111);
    e_cnt = e_cnt + 4'd1;
    cyc("stp_halt",  e_halt(),      4'b1111);
    cyc("stp_start", e_halt(),      4'b1111, 1'b0, 1'b0, 1'b1);

    // watchdog: no ack for 8 cycles
    for (int i = 0; i < 8; i++) cyc("to_wait", e_fetch(1'b0), 4'b0011);
    e_berr = 1'b1;
    cyc("to_halt",  e_halt(), 4'b0011);
    cyc("to_start", e_halt(), 4'b0011, 1'b0, 1'b0, 1'b1);
    e_berr = 1'b0;

    // ack on the 8th cycle wins over the timeout
    for (int i = 0; i < 7; i++) cyc("to8_wait", e_fetch(1'b0), 4'b0011);
    cyc("to8_ack",  e_fetch(1'b1), 4'b0011, 1'b1);
    cyc("to8_dec",  e_decode(),    4'b0011);
    cyc("to8_exec", e_acc(4'b0000), 4'b0011);
    e_cnt = e_cnt + 4'd1;

    // counter wrap 15 -> 0
    exec_acc("w1", 4'b0011, 4'b0000);
    exec_acc("w2", 4'b0011, 4'b0000);
    exec_acc("w3", 4'b0011, 4'b0000);
    cyc("wrap_fetch", e_fetch(1'b0), 4'b0001);

    // reset during OPWR with ack pending
    cyc("rs_fetch", e_fetch(1'b1), 4'b0001, 1'b1);
    cyc("rs_dec",   e_decode(),    4'b0001);
    cyc("rs_opwr",  base(),        4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    e_cnt = 4'd0;
    cyc("rs_next",  base(),        4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    hx = '0; hx.halted = 1'b1;
    chk_h("h_rst_opwr", hx);
    cyc("rs_fetch2", e_fetch(1'b0), 4'b0011);

    // second instance: restart from HALT
    start_h = 1'b1;
    cyc("rs_fetch3", e_fetch(1'b0), 4'b0011);
    start_h = 1'b0;
    hx = '0; hx.mem_req = 1'b1;
    chk_h("h_start_fetch", hx);

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
